// File: rtl/rst_sync_reg_bank.sv
// Multi-channel register bank: async active-low reset, synchronised release,
// programmable hold period, then per-channel loads gated by Ready.
module rst_sync_reg_bank #(
   parameter int               WIDTH       = 8,
   parameter int               CHANNELS    = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter int               SYNC_STAGES = 2,
   parameter int               HOLD_CYCLES = 4
) (
   input  logic                      clock,
   input  logic                      Rst_n,
   input  logic [CHANNELS*WIDTH-1:0] A,
   input  logic [CHANNELS-1:0]       En,
   input  logic                      Clr,
   output logic [CHANNELS*WIDTH-1:0] Q,
   output logic                      Ready
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rs;
   state_t                 state_reg, state_next;
   logic [7:0]             cnt_reg, cnt_next;
   logic                   ready_reg, ready_next;

   // Release synchroniser: ones ripple in only while Rst_n is high.
   always_ff @(posedge clock or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rs = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= ST_RESET;
         cnt_reg   <= 8'd0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ready_reg <= ready_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ready_next = ready_reg;
      case (state_reg)
         ST_RESET, ST_HOLD: begin
            if (rs) begin
               // Counter stops at the limit, so it can never wrap.
               if (cnt_reg == HOLD_LIM) begin
                  state_next = ST_RUN;
                  ready_next = 1'b1;
               end else begin
                  state_next = ST_HOLD;
                  cnt_next   = cnt_reg + 8'd1;
               end
            end
         end
         ST_RUN: begin
            ready_next = 1'b1;
         end
         default: begin
            state_next = ST_RESET;
            cnt_next   = 8'd0;
            ready_next = 1'b0;
         end
      endcase
   end

   assign Ready = ready_reg;

   // Loads act only on edges where Ready is already high; nothing is queued.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [WIDTH-1:0] q_reg;

         always_ff @(posedge clock or negedge Rst_n) begin
            if (!Rst_n) begin
               q_reg <= RESET_VAL;
            end else if (ready_reg) begin
               if (Clr) begin
                  q_reg <= RESET_VAL;
               end else if (En[gi]) begin
                  q_reg <= A[gi*WIDTH +: WIDTH];
               end
            end
         end

         assign Q[gi*WIDTH +: WIDTH] = q_reg;
      end
   endgenerate

endmodule

// File: doc/rst_sync_reg_bank.md
Name: rst_sync_reg_bank

Overview:
- Parametrised multi-channel data register bank with active-low asynchronous reset.
- Reset asserts asynchronously. Reset release passes through an internal synchroniser, then a programmable hold period.
- A Ready flag marks the point from which loads are accepted.
- Used wherever a registered value must come out of reset cleanly and deterministically (control registers, pipeline heads, flags).

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of independent channels.
- RESET_VAL, 0, WIDTH-bit value loaded into every channel on reset and on Clr.
- SYNC_STAGES, 2, reset-release synchroniser depth (legal values 2..4).
- HOLD_CYCLES, 4, post-synchroniser hold cycles before Ready (legal values 0..255).

Ports:
- clock  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- A      in  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH]
- En     in  CHANNELS  per-channel load enable
- Clr    in  1  synchronous clear of all channels
- Q      out CHANNELS*WIDTH  registered channel outputs
- Ready  out 1  high when the bank accepts Clr/En

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Rst_n low, with no clock edge needed:
  - every Q channel = RESET_VAL;
  - Ready = 0;
  - synchroniser chain = all 0;
  - hold counter = 0;
  - state = RESET.
- Synchroniser: SYNC_STAGES-flop shift chain, shifting in 1 each edge while Rst_n is high. Its output rs is 1 after the SYNC_STAGES-th rising edge following Rst_n rising. Edge 1 is the first edge with Rst_n high.
- States:
  - RESET: rs = 0. Q is held at RESET_VAL. Ready = 0.
  - HOLD: rs = 1 and cnt < HOLD_CYCLES. cnt increments by 1 per edge. Q is held at RESET_VAL. Ready = 0.
  - RUN: entered on the edge where rs = 1 and cnt == HOLD_CYCLES. Ready is registered to 1 on that edge.
- Ready timing:
  - Ready rises after edge SYNC_STAGES + HOLD_CYCLES + 1.
  - With defaults, that is after edge 7.
  - With HOLD_CYCLES = 0, HOLD is skipped and Ready rises after edge SYNC_STAGES + 1.
- cnt width is 8 bits. cnt saturates at HOLD_CYCLES and never wraps.
- RUN, per rising edge, with priority Clr > En[i] > hold:
  - Clr = 1: all channels <= RESET_VAL, regardless of En.
  - Else, En[i] = 1: channel i <= A channel i.
  - Else: channel i holds its value.
- Latency: one cycle from the A/En sample to Q.
- Channels are independent. Any En pattern is legal, including all-ones and all-zeros.
- Clr and En are ignored (not queued) while Ready = 0. Only the edge at which Ready is already 1 acts on them; with defaults, the first effective load is at edge 8.
- Rst_n low mid-HOLD or mid-RUN: immediate return to RESET with all outputs at their reset values. The full synchroniser and hold sequence restarts on release.
- Rst_n glitch low, shorter than a clock period: still a full reset. The synchroniser clears and the sequence restarts.
- Rst_n rising at, or near, a clock edge: at most one extra cycle of release latency. Q and Ready never go X.
- Ready never toggles while Rst_n stays high.

Test Plan:
- Power-up: Rst_n = 0 for 3 cycles, then 1 with defaults, A = 32'hA5A5A5A5, En = 4'hF → Q = 0 and Ready = 0 through edge 7. Ready = 1 after edge 7. Q = 32'hA5A5A5A5 after edge 8.
- Per-channel load: Ready = 1, Q = 0, A = 32'h44332211, En = 4'b0101 → after 1 edge, Q = 32'h00330011. Then En = 0, A changes → Q unchanged.
- Clr priority: Q = 32'hFFFFFFFF, Clr = 1 with En = 4'hF and A = 32'h12345678 → after 1 edge, Q = 32'h00000000. RESET_VAL = 8'h5A build → Q = 32'h5A5A5A5A.
- Mid-operation async reset: in RUN with Q = 32'hDEADBEEF, pull Rst_n low between edges → Q = RESET_VAL and Ready = 0 immediately, before the next edge. On release, Ready returns only after 7 edges again.
- Reset during HOLD: Rst_n low 3 edges into the sequence, then released → Ready rises after edge 7 counted from the new release, not the first.
- Parameter sweep: HOLD_CYCLES = 0, SYNC_STAGES = 3 → Ready after edge 4. HOLD_CYCLES = 255 → Ready after edge 258, with no counter wrap. WIDTH = 1, CHANNELS = 1 behaves as a single resettable D flip-flop with enable.
